// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared definitions for the multicycle controller.
//   state_t     : FSM state encoding (also driven out on state_o for debug)
//   OP_*        : opcode values in instr[15:12]
//   FN_*        : R-type funct values in instr[3:0]
//   ALU_*       : alucontrol encodings
//   ctl_t       : per-state control strobes held in a register
//   next_state  : FSM transition function
//   moore_ctl   : per-state strobe decode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALUWB_R = 4'd4,
    S_ALUWB_I = 4'd5,
    S_MEMADDR = 4'd6,
    S_MEMRD   = 4'd7,
    S_MEMWB   = 4'd8,
    S_MEMWR   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_J     = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_SLT = 4'b0100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // fetch/branch/jump/alu_r are qualifiers: the top combines them with
  // mem_ready, zero or the funct decode to form the few input-dependent strobes.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic       illegal;
    logic       fetch;
    logic       branch;
    logic       alu_r;
    logic [3:0] alu;
  } ctl_t;

  function automatic state_t next_state(state_t s, logic [3:0] op, logic rdy);
    state_t n;
    n = s;
    case (s)
      S_FETCH:   if (rdy) n = S_DECODE;
      S_DECODE:
        case (op)
          OP_RTYPE:     n = S_EXEC_R;
          OP_ADDI:      n = S_EXEC_I;
          OP_LW, OP_SW: n = S_MEMADDR;
          OP_BEQ:       n = S_BRANCH;
          OP_J:         n = S_JUMP;
          default:      n = S_HALT;
        endcase
      S_EXEC_R:  n = S_ALUWB_R;
      S_EXEC_I:  n = S_ALUWB_I;
      S_MEMADDR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (rdy) n = S_MEMWB;
      S_MEMWR:   if (rdy) n = S_FETCH;
      S_ALUWB_R, S_ALUWB_I, S_MEMWB, S_BRANCH, S_JUMP: n = S_FETCH;
      S_HALT:    n = S_HALT;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t moore_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.memread = 1'b1; c.fetch = 1'b1; end
      S_EXEC_R:  c.alu_r = 1'b1;
      S_ALUWB_R: begin c.alu_r = 1'b1; c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_EXEC_I:  begin c.alusrc = 1'b1; c.alu = ALU_ADD; end
      S_ALUWB_I: begin c.alusrc = 1'b1; c.alu = ALU_ADD; c.regwrite = 1'b1; end
      S_MEMADDR: begin c.alusrc = 1'b1; c.alu = ALU_ADD; end
      S_MEMRD:   begin c.alusrc = 1'b1; c.alu = ALU_ADD; c.memread = 1'b1; end
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      S_MEMWR:   begin c.alusrc = 1'b1; c.alu = ALU_ADD; c.memwrite = 1'b1; end
      S_BRANCH:  begin c.branch = 1'b1; c.alu = ALU_SUB; end
      S_JUMP:    c.jump = 1'b1;
      S_HALT:    c.illegal = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec -- R-type funct to alucontrol decode (combinational).
//   funct      in  4  instr[3:0]
//   alucontrol out 4  ALU operation; unknown funct falls back to ADD
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] funct,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller -- multicycle CPU control FSM.
//   clk, reset            : clock, synchronous active-high reset
//   instr[15:0]           : IR contents (opcode [15:12], funct [3:0])
//   zero, mem_ready       : ALU zero flag, memory access-complete handshake
//   memtoreg..pcsrc       : datapath strobes; alucontrol[3:0] ALU select
//   memread, memwrite     : memory request strobes
//   irwrite, pcen         : IR load / PC update enables
//   illegal               : sticky undefined-opcode flag (HALT)
//   state_o[3:0]          : current state, debug
//   cycle_count, instr_count [31:0] : only with MC_CONTROLLER_PERF_EN defined
// Strobes are registered per state; only irwrite/pcen (FETCH), pcen/pcsrc
// (BRANCH) and alucontrol (R-type states) mix in live inputs. Every output
// is forced low while reset is high, so an aborted access cannot leak a pulse.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             regdst,
  output logic             regwrite,
  output logic             jump,
  output logic             pcsrc,
  output logic [3:0]       alucontrol,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             illegal,
  output logic [3:0]       state_o
`ifdef MC_CONTROLLER_PERF_EN
  ,
  output logic [31:0]      cycle_count,
  output logic [31:0]      instr_count
`endif
);

  state_t     state;
  state_t     nxt;
  ctl_t       ctl;
  logic [3:0] alu_r_ctl;
  logic       act;
  logic       unused_bits;

  assign unused_bits = ^instr[11:4];
  assign act         = ~reset;
  assign nxt         = next_state(state, instr[15:12], mem_ready);

  alu_dec u_alu_dec (
    .funct      (instr[3:0]),
    .alucontrol (alu_r_ctl)
  );

  // Strobes for the state being entered are decoded alongside the state
  // update, so they are flop outputs in the cycle the state is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctl   <= moore_ctl(S_FETCH);
    end else begin
      state <= nxt;
      ctl   <= moore_ctl(nxt);
    end
  end

  assign memread    = act & ctl.memread;
  assign memwrite   = act & ctl.memwrite;
  assign memtoreg   = act & ctl.memtoreg;
  assign alusrc     = act & ctl.alusrc;
  assign regdst     = act & ctl.regdst;
  assign regwrite   = act & ctl.regwrite;
  assign jump       = act & ctl.jump;
  assign illegal    = act & ctl.illegal;
  assign irwrite    = act & ctl.fetch & mem_ready;
  assign pcsrc      = act & ctl.branch & zero;
  assign pcen       = act & ((ctl.fetch & mem_ready) | (ctl.branch & zero) | ctl.jump);
  assign alucontrol = act ? (ctl.alu_r ? alu_r_ctl : ctl.alu) : 4'd0;
  assign state_o    = act ? state : 4'd0;

`ifdef MC_CONTROLLER_PERF_EN
  // An instruction retires when any non-FETCH state hands back to FETCH;
  // HALT never does, and FETCH holding on itself is a wait, not a retire.
  logic retire;
  assign retire = (state != S_FETCH) && (nxt == S_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        memtoreg, alusrc, regdst, regwrite, jump, pcsrc;
  logic [3:0]  alucontrol;
  logic        memread, memwrite, irwrite, pcen, illegal;
  logic [3:0]  state_o;
`ifdef MC_CONTROLLER_PERF_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .jump       (jump),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .illegal    (illegal),
    .state_o    (state_o)
`ifdef MC_CONTROLLER_PERF_EN
    ,
    .cycle_count(cycle_count),
    .instr_count(instr_count)
`endif
  );

  // output bundle bit positions
  localparam logic [10:0] MR = 11'b100_0000_0000, MW = 11'b010_0000_0000,
                          IRW = 11'b001_0000_0000, PCE = 11'b000_1000_0000,
                          RW = 11'b000_0100_0000, M2R = 11'b000_0010_0000,
                          ASRC = 11'b000_0001_0000, RDST = 11'b000_0000_1000,
                          JMP = 11'b000_0000_0100, PCS = 11'b000_0000_0010,
                          ILL = 11'b000_0000_0001;
  localparam logic [10:0] FET = MR | IRW | PCE;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, ER = 4'd2, EI = 4'd3, WR = 4'd4,
                         WI = 4'd5, MA = 4'd6, MRD = 4'd7, MWB = 4'd8,
                         MWR = 4'd9, BR = 4'd10, JP = 4'd11, HL = 4'd12;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;

  wire [10:0] obus = {memread, memwrite, irwrite, pcen, regwrite, memtoreg,
                      alusrc, regdst, jump, pcsrc, illegal};

  typedef struct {
    logic        rst;
    logic [15:0] in;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [10:0] o;
    logic [3:0]  alu;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic r, logic [15:0] in, logic z, logic rdy,
                              logic [3:0] st, logic [10:0] o, logic [3:0] alu);
    vec_t v;
    v.rst = r; v.in = in; v.z = z; v.rdy = rdy; v.st = st; v.o = o; v.alu = alu;
    vt.push_back(v);
  endfunction

  // One cycle: drive inputs at the falling edge, sample shortly after.
  task automatic step(input logic r, input logic [15:0] in, input logic z,
                      input logic rdy, input logic [3:0] est,
                      input logic [10:0] eo, input logic [3:0] ealu,
                      input string nm);
    @(negedge clk);
    reset = r; instr = in; zero = z; mem_ready = rdy;
    #1;
    checks++;
    if ({state_o, obus, alucontrol} !== {est, eo, ealu}) begin
      errors++;
      $display("FAIL %s: got state=%0d out=%b alu=%b, expected state=%0d out=%b alu=%b",
               nm, state_o, obus, alucontrol, est, eo, ealu);
    end
  endtask

  initial begin
    // reset
    add(1, 16'h0000, 0, 1, FE, 11'd0, A_AND);
    add(1, 16'h0000, 0, 1, FE, 11'd0, A_AND);
    // RTYPE OR, zero-wait: 4 cycles, regwrite only in the 4th
    add(0, 16'h0123, 0, 1, FE, FET, A_AND);
    add(0, 16'h0123, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h0123, 0, 1, ER, 11'd0, A_OR);
    add(0, 16'h0123, 0, 1, WR, RDST | RW, A_OR);
    // fetch wait, then RTYPE SUB
    add(0, 16'h0FF1, 0, 0, FE, MR, A_AND);
    add(0, 16'h0FF1, 0, 1, FE, FET, A_AND);
    add(0, 16'h0FF1, 0, 0, DE, 11'd0, A_AND);
    add(0, 16'h0FF1, 0, 0, ER, 11'd0, A_SUB);
    add(0, 16'h0FF1, 0, 0, WR, RDST | RW, A_SUB);
    // RTYPE SLT
    add(0, 16'h0004, 0, 1, FE, FET, A_AND);
    add(0, 16'h0004, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h0004, 0, 1, ER, 11'd0, A_SLT);
    add(0, 16'h0004, 0, 1, WR, RDST | RW, A_SLT);
    // RTYPE unknown funct -> ADD
    add(0, 16'h0AB9, 0, 1, FE, FET, A_AND);
    add(0, 16'h0AB9, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h0AB9, 0, 1, ER, 11'd0, A_ADD);
    add(0, 16'h0AB9, 0, 1, WR, RDST | RW, A_ADD);
    // ADDI
    add(0, 16'h2345, 0, 1, FE, FET, A_AND);
    add(0, 16'h2345, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h2345, 0, 1, EI, ASRC, A_ADD);
    add(0, 16'h2345, 0, 1, WI, ASRC | RW, A_ADD);
    // LW with 3 wait cycles in MEMRD; ready in DECODE/MEMADDR is ignored
    add(0, 16'h4567, 0, 1, FE, FET, A_AND);
    add(0, 16'h4567, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h4567, 0, 1, MA, ASRC, A_ADD);
    add(0, 16'h4567, 0, 0, MRD, ASRC | MR, A_ADD);
    add(0, 16'h4567, 0, 0, MRD, ASRC | MR, A_ADD);
    add(0, 16'h4567, 0, 0, MRD, ASRC | MR, A_ADD);
    add(0, 16'h4567, 0, 1, MRD, ASRC | MR, A_ADD);
    add(0, 16'h4567, 0, 0, MWB, M2R | RW, A_AND);
    // SW with one wait cycle
    add(0, 16'h5ABC, 0, 1, FE, FET, A_AND);
    add(0, 16'h5ABC, 0, 0, DE, 11'd0, A_AND);
    add(0, 16'h5ABC, 0, 0, MA, ASRC, A_ADD);
    add(0, 16'h5ABC, 0, 0, MWR, ASRC | MW, A_ADD);
    add(0, 16'h5ABC, 0, 1, MWR, ASRC | MW, A_ADD);
    // BEQ taken
    add(0, 16'h3000, 1, 1, FE, FET, A_AND);
    add(0, 16'h3000, 1, 1, DE, 11'd0, A_AND);
    add(0, 16'h3000, 1, 1, BR, PCS | PCE, A_SUB);
    // BEQ not taken
    add(0, 16'h3000, 0, 1, FE, FET, A_AND);
    add(0, 16'h3000, 0, 1, DE, 11'd0, A_AND);
    add(0, 16'h3000, 0, 1, BR, 11'd0, A_SUB);
    // J
    add(0, 16'h1ABC, 1, 1, FE, FET, A_AND);
    add(0, 16'h1ABC, 1, 1, DE, 11'd0, A_AND);
    add(0, 16'h1ABC, 1, 1, JP, JMP | PCE, A_AND);
    add(0, 16'h1ABC, 0, 0, FE, MR, A_AND);

    foreach (vt[i]) step(vt[i].rst, vt[i].in, vt[i].z, vt[i].rdy,
                         vt[i].st, vt[i].o, vt[i].alu, $sformatf("vec%0d", i));

    // illegal opcode: HALT is sticky whatever mem_ready/zero do
    step(0, 16'hF000, 0, 1, FE, FET, A_AND, "halt_fetch");
    step(0, 16'hF000, 0, 1, DE, 11'd0, A_AND, "halt_decode");
    for (int i = 0; i < 20; i++)
      step(0, 16'h0000, i[1], i[0], HL, ILL, A_AND, "halt_sticky");
    step(1, 16'h0000, 0, 1, FE, 11'd0, A_AND, "halt_reset");
    step(0, 16'h0000, 0, 0, FE, MR, A_AND, "halt_cleared");

    // reset during a MEMWR wait aborts the store with no pcen/memwrite pulse
    step(0, 16'h5000, 0, 1, FE, FET, A_AND, "abort_fetch");
    step(0, 16'h5000, 0, 0, DE, 11'd0, A_AND, "abort_decode");
    step(0, 16'h5000, 0, 0, MA, ASRC, A_ADD, "abort_memaddr");
    step(0, 16'h5000, 0, 0, MWR, ASRC | MW, A_ADD, "abort_memwr");
    step(1, 16'h5000, 0, 1, FE, 11'd0, A_AND, "abort_reset");
    step(0, 16'h5000, 0, 0, FE, MR, A_AND, "abort_after1");
    step(0, 16'h5000, 0, 0, FE, MR, A_AND, "abort_after2");

`ifdef MC_CONTROLLER_PERF_EN
    // preload both counters in the JUMP cycle so the next edge wraps both
    step(0, 16'h1000, 0, 1, FE, FET, A_AND, "perf_fetch");
    step(0, 16'h1000, 0, 1, DE, 11'd0, A_AND, "perf_decode");
    step(0, 16'h1000, 0, 0, JP, JMP | PCE, A_AND, "perf_jump");
    force dut.cycle_count = 32'hFFFF_FFFF;
    force dut.instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count;
    release dut.instr_count;
    @(posedge clk);
    #1;
    checks++;
    if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL perf_wrap: got cycle=%h instr=%h, expected 0 and 0",
               cycle_count, instr_count);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
